// File: rtl/mem_req_pkg.sv
// Shared types for the memory request issuer: request/response records and the byte-to-word shift.
// Field widths here fix DATA_WIDTH, ADDR_WIDTH and TAG_WIDTH of mem_req_issuer.
package mem_req_pkg;

    localparam int REQ_DATA_W = 32;
    localparam int REQ_ADDR_W = 32;
    localparam int REQ_TAG_W  = 4;
    localparam int WORD_SHIFT = 2;

    typedef struct packed {
        logic                  is_store;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
        logic [REQ_TAG_W-1:0]  tag;
    } req_t;

    typedef struct packed {
        logic [REQ_DATA_W-1:0] rdata;
        logic [REQ_TAG_W-1:0]  tag;
        logic                  is_store;
        logic                  err;
    } resp_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request buffer: synchronous FIFO of req_t, power-of-two depth, wrapping pointers.
module mem_req_fifo
    import mem_req_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  req_t          push_data,
    input  logic          pop,
    output req_t          head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    req_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_issuer.sv
// Pipeline-side front end for the word memory: buffers load/store requests, issues them in order
// and returns one tagged response each. MEM_REQ_BOUNDS_CHECK_EN adds a word-index range check.
module mem_req_issuer
    import mem_req_pkg::*;
#(
    parameter int DATA_WIDTH = REQ_DATA_W,
    parameter int ADDR_WIDTH = REQ_ADDR_W,
    parameter int MEM_SIZE   = 1024,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_WIDTH  = REQ_TAG_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic                  resp_is_store,
    output logic                  resp_err,
    output logic                  mem_read_enable,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef MEM_REQ_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK = 1'b1;
`else
    localparam bit BOUNDS_CHECK = 1'b0;
`endif

    req_t                  w_push_req;
    req_t                  w_head;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [ADDR_WIDTH-1:0] w_index;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic                  w_err;
    logic                  w_issue;
    slot_state_t           r_slot_state;
    resp_t                 r_resp;

    // Both sides use valid/ready: a transfer happens on a rising edge where valid && ready are both
    // high; valid and its payload are held by the sender until that edge.
    assign req_ready  = (w_count < CW'(FIFO_DEPTH));
    assign w_push     = req_valid && !w_full;
    assign w_push_req = '{is_store: req_is_store, addr: req_addr, wdata: req_wdata, tag: req_tag};

    mem_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_req),
        .pop       (w_issue),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign w_index        = w_head.addr >> WORD_SHIFT;
    assign w_misaligned   = |w_head.addr[WORD_SHIFT-1:0];
    assign w_out_of_range = BOUNDS_CHECK && (w_index >= ADDR_WIDTH'(MEM_SIZE));
    assign w_err          = w_misaligned || w_out_of_range;

    // Reset gates issue so no memory access can start in a cycle with reset high.
    assign w_issue = !w_empty && ((r_slot_state == SLOT_EMPTY) || resp_ready) && !reset;

    assign mem_read_enable  = w_issue && !w_head.is_store && !w_err;
    assign mem_write_enable = w_issue && w_head.is_store && !w_err;
    assign mem_read_addr    = w_index;
    assign mem_write_addr   = w_index;
    assign mem_write_data   = w_head.wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_state <= SLOT_EMPTY;
            r_resp       <= '0;
        end else if (w_issue) begin
            r_slot_state    <= SLOT_FULL;
            r_resp.rdata    <= mem_read_enable ? mem_read_data : '0;
            r_resp.tag      <= w_head.tag;
            r_resp.is_store <= w_head.is_store;
            r_resp.err      <= w_err;
        end else if ((r_slot_state == SLOT_FULL) && resp_ready) begin
            r_slot_state <= SLOT_EMPTY;
        end
    end

    assign resp_valid    = (r_slot_state == SLOT_FULL);
    assign resp_rdata    = r_resp.rdata;
    assign resp_tag      = r_resp.tag;
    assign resp_is_store = r_resp.is_store;
    assign resp_err      = r_resp.err;

endmodule

// File: tb/tb_mem_req_issuer.sv
// Bench for mem_req_issuer: directed scenarios plus a randomized run against an in-order memory
// model; a background monitor scores responses and memory-port activity against expected queues.
module tb_mem_req_issuer;

    localparam int DW        = 32;
    localparam int AW        = 32;
    localparam int TW        = 4;
    localparam int MEM_SIZE  = 1024;
    localparam int DEV_WORDS = 2048;
`ifdef MEM_REQ_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_is_store = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [TW-1:0] req_tag = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_rdata;
    logic [TW-1:0] resp_tag;
    logic          resp_is_store;
    logic          resp_err;
    logic          mem_read_enable;
    logic [AW-1:0] mem_read_addr;
    logic [DW-1:0] mem_read_data;
    logic          mem_write_enable;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_write_data;

    int errors = 0;
    int checks = 0;
    bit rand_ready = 1'b0;

    logic [37:0] exp_q[$];
    logic [31:0] exp_rd_q[$];
    logic [63:0] exp_wr_q[$];
    logic [31:0] ref_mem[int];

    mem_req_issuer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MEM_SIZE), .FIFO_DEPTH(4), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_tag(resp_tag), .resp_is_store(resp_is_store), .resp_err(resp_err),
        .mem_read_enable(mem_read_enable), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data),
        .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_pat(input logic [31:0] idx);
        return (idx * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Memory device: combinational read, synchronous write; unwritten words hold init_pat.
    logic [31:0] dev_mem [DEV_WORDS];
    bit          dev_wr  [DEV_WORDS];

    always_comb begin
        mem_read_data = '0;
        if (mem_read_addr < DEV_WORDS)
            mem_read_data = dev_wr[mem_read_addr[10:0]] ? dev_mem[mem_read_addr[10:0]]
                                                        : init_pat(mem_read_addr);
    end

    always @(posedge clk) begin
        if (mem_write_enable && mem_write_addr < DEV_WORDS) begin
            dev_mem[mem_write_addr[10:0]] <= mem_write_data;
            dev_wr[mem_write_addr[10:0]]  <= 1'b1;
        end
    end

    // Reference model, applied in acceptance order: responses, reads and writes are all in order.
    task automatic model_accept(input logic st, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] tag);
        logic [31:0] idx;
        logic [31:0] cur;
        bit          err;
        idx = addr / 4;
        err = (addr % 4 != 0) || (BOUNDS_EN && idx >= MEM_SIZE);
        if (err) begin
            exp_q.push_back({32'h0, tag, st, 1'b1});
        end else if (st) begin
            ref_mem[idx] = wdata;
            exp_wr_q.push_back({idx, wdata});
            exp_q.push_back({32'h0, tag, 1'b1, 1'b0});
        end else begin
            cur = ref_mem.exists(idx) ? ref_mem[idx] : init_pat(idx);
            exp_rd_q.push_back(idx);
            exp_q.push_back({cur, tag, 1'b0, 1'b0});
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic [37:0] got;
        logic [37:0] exp_v;
        logic [63:0] exp_w;
        logic [31:0] exp_r;
        logic [37:0] hold_val = '0;
        bit hold_prev = 1'b0;
        bit reset_prev = 1'b1;
        forever begin
            @(negedge clk);
            got = {resp_rdata, resp_tag, resp_is_store, resp_err};
            if (reset) begin
                checks++;
                if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_enables: rd=%b wr=%b, required 0 0", mem_read_enable, mem_write_enable);
                end
            end else begin
                if (mem_write_enable === 1'b1) begin
                    checks++;
                    if (exp_wr_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_write_addr, mem_write_data);
                    end else begin
                        exp_w = exp_wr_q.pop_front();
                        if ({mem_write_addr, mem_write_data} !== exp_w) begin
                            errors++;
                            $display("FAIL write_port: got %h, required %h", {mem_write_addr, mem_write_data}, exp_w);
                        end
                    end
                end
                if (mem_read_enable === 1'b1) begin
                    checks++;
                    if (exp_rd_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_read: addr=%h, required no read", mem_read_addr);
                    end else begin
                        exp_r = exp_rd_q.pop_front();
                        if (mem_read_addr !== exp_r) begin
                            errors++;
                            $display("FAIL read_port: addr=%h, required %h", mem_read_addr, exp_r);
                        end
                    end
                end
                if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp: got %h, required none", got);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (got !== exp_v) begin
                            errors++;
                            $display("FAIL resp: got rdata/tag/st/err=%h, required %h", got, exp_v);
                        end
                    end
                end
                if (hold_prev && !reset_prev) begin
                    checks++;
                    if (resp_valid !== 1'b1 || got !== hold_val) begin
                        errors++;
                        $display("FAIL resp_stable: valid=%b resp=%h, required 1 %h", resp_valid, got, hold_val);
                    end
                end
            end
            hold_prev  = (resp_valid === 1'b1) && (resp_ready === 1'b0);
            hold_val   = got;
            reset_prev = reset;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) resp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic st, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] tag);
        int budget;
        budget = 0;
        step();
        req_valid = 1'b1; req_is_store = st; req_addr = addr; req_wdata = wdata; req_tag = tag;
        while (!req_ready && budget < 200) begin
            step();
            budget++;
        end
        if (!req_ready) begin
            errors++; checks++;
            $display("FAIL send_timeout: req_ready=%b, required 1 within 200 cycles", req_ready);
            req_valid = 1'b0;
        end else begin
            model_accept(st, addr, wdata, tag);
        end
    endtask

    task automatic idle();
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        rand_ready = 1'b0;
        resp_ready = 1'b1;
        while ((exp_q.size() != 0 || resp_valid) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending resp=%0d rd=%0d wr=%0d, required 0 0 0",
                     exp_q.size(), exp_rd_q.size(), exp_wr_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_rdata, resp_tag, resp_is_store, resp_err} !== {1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: ready=%b valid=%b rdata=%h tag=%h st=%b err=%b, required 1 0 0 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_tag, resp_is_store, resp_err);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_store_single();
        resp_ready = 1'b1;
        send(1'b1, 32'h10, 32'hDEAD_BEEF, 4'd3);
        idle();
        @(negedge clk);
        checks++;
        if ({mem_write_enable, mem_write_addr, mem_write_data, resp_valid} !== {1'b1, 32'd4, 32'hDEAD_BEEF, 1'b0}) begin
            errors++;
            $display("FAIL store_access: we=%b addr=%h data=%h valid=%b, required 1 4 deadbeef 0",
                     mem_write_enable, mem_write_addr, mem_write_data, resp_valid);
        end
        @(negedge clk);
        checks++;
        if ({mem_write_enable, resp_valid, resp_tag, resp_is_store, resp_err} !== {1'b0, 1'b1, 4'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL store_resp: we=%b valid=%b tag=%h st=%b err=%b, required 0 1 3 1 0",
                     mem_write_enable, resp_valid, resp_tag, resp_is_store, resp_err);
        end
        wait_drain();
    endtask

    task automatic test_store_load();
        logic [3:0]  tags[$];
        logic [31:0] ld_data;
        logic [31:0] rd_addr;
        ld_data = 32'hFFFF_FFFF;
        rd_addr = 32'hFFFF_FFFF;
        resp_ready = 1'b1;
        send(1'b1, 32'h10, 32'h0000_1234, 4'd4);
        send(1'b0, 32'h10, 32'h0, 4'd5);
        idle();
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (mem_read_enable === 1'b1) rd_addr = mem_read_addr;
            if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
                tags.push_back(resp_tag);
                if (resp_tag == 4'd5) ld_data = resp_rdata;
            end
        end
        checks++;
        if (rd_addr !== 32'd4) begin
            errors++;
            $display("FAIL raw_read_addr: got %h, required 4", rd_addr);
        end
        checks++;
        if (tags.size() != 2 || tags[0] !== 4'd4 || tags[1] !== 4'd5 || ld_data !== 32'h1234) begin
            errors++;
            $display("FAIL raw_order: count=%0d rdata=%h, required 2 responses tags 4,5 rdata 1234",
                     tags.size(), ld_data);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int  nvalid;
        bit  pending;
        bit  accept_now;
        step();
        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            req_valid = 1'b1; req_is_store = 1'b0; req_addr = 32'h40 + i * 4; req_tag = 4'(i);
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_accept_%0d: req_ready=%b, required 1", i, req_ready);
            end
            model_accept(1'b0, req_addr, 32'h0, req_tag);
        end
        step();
        req_addr = 32'h54; req_tag = 4'd5;
        step();
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: req_ready=%b resp_valid=%b, required 0 1", req_ready, resp_valid);
        end
        resp_ready = 1'b1;
        pending = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 7; c++) begin
            accept_now = 1'b0;
            @(negedge clk);
            if (resp_valid === 1'b1) nvalid++;
            if (pending && req_ready) begin
                model_accept(1'b0, 32'h54, 32'h0, 4'd5);
                pending = 1'b0;
                accept_now = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accept_now) req_valid = 1'b0;
        end
        checks++;
        if (nvalid != 6 || pending) begin
            errors++;
            $display("FAIL bp_drain: valid cycles=%0d pending=%b, required 6 0", nvalid, pending);
        end
        req_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_misaligned();
        bit got_resp;
        bit saw_en;
        logic [31:0] rdata;
        logic err;
        got_resp = 1'b0; saw_en = 1'b0; rdata = 32'hFFFF_FFFF; err = 1'b0;
        resp_ready = 1'b1;
        send(1'b0, 32'h13, 32'h0, 4'd7);
        send(1'b1, 32'h22, 32'hCAFE_F00D, 4'd9);
        idle();
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) saw_en = 1'b1;
            if (resp_valid === 1'b1 && resp_tag == 4'd7) begin
                got_resp = 1'b1; rdata = resp_rdata; err = resp_err;
            end
        end
        checks++;
        if (!got_resp || err !== 1'b1 || rdata !== 32'h0 || saw_en) begin
            errors++;
            $display("FAIL misaligned: resp=%b err=%b rdata=%h enables_seen=%b, required 1 1 0 0",
                     got_resp, err, rdata, saw_en);
        end
        wait_drain();
    endtask

    task automatic test_bounds();
        logic [31:0] rd_addr;
        logic err;
        bit got_resp;
        rd_addr = 32'hFFFF_FFFF; err = 1'b0; got_resp = 1'b0;
        resp_ready = 1'b1;
        send(1'b0, 32'h1000, 32'h0, 4'd8);
        idle();
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (mem_read_enable === 1'b1) rd_addr = mem_read_addr;
            if (resp_valid === 1'b1 && resp_tag == 4'd8) begin
                got_resp = 1'b1; err = resp_err;
            end
        end
        checks++;
        if (!got_resp || err !== BOUNDS_EN || rd_addr !== (BOUNDS_EN ? 32'hFFFF_FFFF : 32'd1024)) begin
            errors++;
            $display("FAIL bounds: resp=%b err=%b read_addr=%h, required 1 %b %h",
                     got_resp, err, rd_addr, BOUNDS_EN, BOUNDS_EN ? 32'hFFFF_FFFF : 32'd1024);
        end
        wait_drain();
    endtask

    task automatic test_random();
        logic        st;
        logic [31:0] addr;
        int          r;
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            st = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 15);
            if (r < 2)       addr = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
            else if (r == 2) addr = (MEM_SIZE + $urandom_range(0, 50)) * 4;
            else             addr = $urandom_range(0, 15) * 4;
            send(st, addr, $urandom, 4'($urandom));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        wait_drain();
    endtask

    task automatic test_reset_mid();
        bit saw_activity;
        saw_activity = 1'b0;
        step();
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 32'h80 + i * 4, 32'h0, 4'(10 + i));
        step();
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: req_ready=%b resp_valid=%b, required 1 1", req_ready, resp_valid);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        exp_rd_q.delete();
        exp_wr_q.delete();
        @(negedge clk);
        checks++;
        if ({resp_valid, req_ready, mem_read_enable, mem_write_enable} !== 4'b0100) begin
            errors++;
            $display("FAIL rst_mid: valid=%b ready=%b rd=%b wr=%b, required 0 1 0 0",
                     resp_valid, req_ready, mem_read_enable, mem_write_enable);
        end
        resp_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0)
                saw_activity = 1'b1;
        end
        checks++;
        if (saw_activity) begin
            errors++;
            $display("FAIL rst_discard: activity after reset=%b, required 0", saw_activity);
        end
        send(1'b0, 32'h10, 32'h0, 4'd1);
        idle();
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_store_single();
        test_store_load();
        test_backpressure();
        test_misaligned();
        test_bounds();
        test_random();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
